// File: rtl/biquad_band_scheduler.sv
// Time-multiplexed biquad: one signed MAC shared across NUM_CH bands, five taps per band, then write-back.
// Optional macro SHADOW_COEFF_EN adds a shadow coefficient bank with a commit-armed swap (coeff_commit_in).
module biquad_band_scheduler #(
  parameter int WIDTH       = 24,
  parameter int NUM_CH      = 16,
  parameter int COEFF_WIDTH = 32,
  parameter int SHIFT       = 20
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      sample_valid_in,
  input  logic [WIDTH-1:0]          sample_in,
  input  logic                      coeff_we_in,
  input  logic [$clog2(NUM_CH)-1:0] coeff_ch_in,
  input  logic [2:0]                coeff_idx_in,
  input  logic [COEFF_WIDTH-1:0]    coeff_data_in,
`ifdef SHADOW_COEFF_EN
  input  logic                      coeff_commit_in,
`endif
  output logic                      coeff_ready_out,
  output logic                      out_valid_out,
  output logic [$clog2(NUM_CH)-1:0] out_ch_out,
  output logic [WIDTH-1:0]          sample_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      overrun_out,
  output logic [1:0]                fsm_state_out
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (WIDTH - 1));

  // Handshakes: a sample is taken only on sample_valid_in while idle; a coefficient
  // write lands only on a cycle where coeff_we_in and coeff_ready_out are both high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CH_W-1:0]              ch;
  logic [2:0]                   tap;
  logic signed [WIDTH-1:0]      x, x1, x2;
  logic signed [WIDTH-1:0]      y1 [NUM_CH];
  logic signed [WIDTH-1:0]      y2 [NUM_CH];
  logic signed [63:0]           acc;
  logic signed [COEFF_WIDTH-1:0] coef_act [NUM_CH][5];

  logic                         out_valid_q, done_q, overrun_q;
  logic [CH_W-1:0]              out_ch_q;
  logic signed [WIDTH-1:0]      sample_q;

  logic                         accept, coeff_idx_ok;
  logic signed [COEFF_WIDTH-1:0] coef_sel;
  logic signed [WIDTH-1:0]      data_sel;
  logic signed [63:0]           coef_ext, data_ext, prod, acc_next, shifted;
  logic signed [WIDTH-1:0]      y_sat;

  assign accept        = sample_valid_in && (state == IDLE);
  assign coeff_idx_ok  = (coeff_idx_in < 3'd5);
  assign busy_out      = (state != IDLE);
  assign out_valid_out = out_valid_q;
  assign out_ch_out    = out_ch_q;
  assign sample_out    = sample_q;
  assign done_out      = done_q;
  assign overrun_out   = overrun_q;
  assign fsm_state_out = state;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_valid_in) state_next = MAC;
      MAC:     if (tap == 3'd4) state_next = WB;
      WB:      state_next = (ch == LAST_CH) ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
  end

  // Operand select: taps 0..2 are feed-forward on the shared input history,
  // taps 3..4 are feedback on this band's own output history.
  always_comb begin
    coef_sel = coef_act[ch][tap];
    case (tap)
      3'd0:    data_sel = x;
      3'd1:    data_sel = x1;
      3'd2:    data_sel = x2;
      3'd3:    data_sel = y1[ch];
      default: data_sel = y2[ch];
    endcase
    coef_ext = 64'(coef_sel);
    data_ext = 64'(data_sel);
    prod     = coef_ext * data_ext;
    if (tap == 3'd0)     acc_next = prod;
    else if (tap < 3'd3) acc_next = acc + prod;
    else                 acc_next = acc - prod;
    shifted = acc_next >>> SHIFT;
    if (shifted > SAT_MAX)      y_sat = SAT_MAX[WIDTH-1:0];
    else if (shifted < SAT_MIN) y_sat = SAT_MIN[WIDTH-1:0];
    else                        y_sat = shifted[WIDTH-1:0];
  end

  // The result is registered on the last MAC tap so it is visible during WB.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ch          <= '0;
      tap         <= '0;
      x           <= '0;
      x1          <= '0;
      x2          <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      out_ch_q    <= '0;
      sample_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        y1[c] <= '0;
        y2[c] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (sample_valid_in && state != IDLE) overrun_q <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            x   <= sample_in;
            ch  <= '0;
            tap <= '0;
          end
        end
        MAC: begin
          acc <= acc_next;
          tap <= (tap == 3'd4) ? 3'd0 : tap + 3'd1;
          if (tap == 3'd4) begin
            sample_q    <= y_sat;
            out_ch_q    <= ch;
            out_valid_q <= 1'b1;
            done_q      <= (ch == LAST_CH);
          end
        end
        WB: begin
          y2[ch] <= y1[ch];
          y1[ch] <= sample_q;
          if (ch == LAST_CH) begin
            x2 <= x1;
            x1 <= x;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHADOW_COEFF_EN
  logic signed [COEFF_WIDTH-1:0] coef_sh [NUM_CH][5];
  logic                          commit_pending;

  assign coeff_ready_out = 1'b1;

  // A write in the swap cycle is folded into the copy so it is never lost.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      commit_pending <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < 5; t++) begin
          coef_act[c][t] <= '0;
          coef_sh[c][t]  <= '0;
        end
      end
    end else begin
      if (coeff_we_in && coeff_idx_ok) coef_sh[coeff_ch_in][coeff_idx_in] <= coeff_data_in;
      if (state == IDLE && (commit_pending || coeff_commit_in)) begin
        commit_pending <= 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          for (int t = 0; t < 5; t++) coef_act[c][t] <= coef_sh[c][t];
        end
        if (coeff_we_in && coeff_idx_ok) coef_act[coeff_ch_in][coeff_idx_in] <= coeff_data_in;
      end else if (coeff_commit_in) begin
        commit_pending <= 1'b1;
      end
    end
  end
`else
  assign coeff_ready_out = ~busy_out;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < 5; t++) coef_act[c][t] <= '0;
      end
    end else if (coeff_we_in && coeff_ready_out && coeff_idx_ok) begin
      coef_act[coeff_ch_in][coeff_idx_in] <= coeff_data_in;
    end
  end
`endif

endmodule
